// File: rtl/lane_gene_compact_pkg.sv
// Shared definitions for the gene compaction lane: phase encodings and the control FSM states.
package lane_gene_compact_pkg;

  localparam logic [1:0] ST_NODE = 2'b00;
  localparam logic [1:0] ST_CONN = 2'b10;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_NODE,
    FSM_CONN,
    FSM_DRAIN
  } fsm_t;

  function automatic logic is_gene_phase(input logic [1:0] st);
    return (st == ST_NODE) || (st == ST_CONN);
  endfunction

endpackage

// File: rtl/lane_gene_fifo.sv
// Synchronous FIFO holding tagged genes; caller guarantees no push when full
// (unless popping) and no pop when empty.
module lane_gene_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lane_gene_compact.sv
// Packs the bubbly surviving-gene stream into a FIFO and re-emits it gap-free with node/conn tags.
// Define LANE_COMPACT_STATS_EN to build the per-genome node/conn/drop counters.
module lane_gene_compact
  import lane_gene_compact_pkg::*;
#(
  parameter int GENE_SZ = 64,
  parameter int ATTR_SZ = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state,
  input  logic [GENE_SZ-1:0] gene_in,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic [GENE_SZ-1:0] gene_out,
  output logic               out_tag,
  output logic               out_valid,
  output logic [ATTR_SZ-1:0] node_cnt,
  output logic [ATTR_SZ-1:0] conn_cnt,
  output logic [ATTR_SZ-1:0] drop_cnt,
  output logic               overflow,
  output logic               done
);

  logic push_req, push, pop, drop, clear;
  logic fifo_full, fifo_empty;
  logic [GENE_SZ:0] head;
  fsm_t fsm_q, fsm_d;

  assign push_req  = in_valid && is_gene_phase(state);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot on the same edge, so a full FIFO still accepts.
  assign push      = push_req && (!fifo_full || pop);
  assign drop      = push_req && fifo_full && !pop;

  lane_gene_fifo #(.W(GENE_SZ + 1), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({state[1], gene_in}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign gene_out = out_valid ? head[GENE_SZ-1:0] : '0;
  assign out_tag  = out_valid & head[GENE_SZ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= FSM_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    clear = 1'b0;
    done  = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        if (state == ST_NODE) begin
          fsm_d = FSM_NODE;
          clear = 1'b1;
        end else if (state == ST_CONN) begin
          fsm_d = FSM_CONN;
        end
      end
      FSM_NODE: begin
        if (state == ST_CONN)      fsm_d = FSM_CONN;
        else if (state != ST_NODE) fsm_d = FSM_DRAIN;
      end
      FSM_CONN: begin
        if (state != ST_CONN) fsm_d = FSM_DRAIN;
      end
      FSM_DRAIN: begin
        // A late push into an empty FIFO must hold off done until it drains too.
        if (fifo_empty && !push) begin
          fsm_d = FSM_IDLE;
          done  = 1'b1;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        overflow <= 1'b0;
    else if (clear) overflow <= drop;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef LANE_COMPACT_STATS_EN
  logic push_node, push_conn;
  logic [ATTR_SZ-1:0] node_q, conn_q, drop_q;

  assign push_node = push && !state[1];
  assign push_conn = push && state[1];

  // The clearing edge may itself carry the genome's first gene, so it seeds rather than zeroes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      node_q <= '0;
      conn_q <= '0;
      drop_q <= '0;
    end else if (clear) begin
      node_q <= ATTR_SZ'(push_node);
      conn_q <= ATTR_SZ'(push_conn);
      drop_q <= ATTR_SZ'(drop);
    end else begin
      if (push_node && node_q != '1) node_q <= node_q + 1'b1;
      if (push_conn && conn_q != '1) conn_q <= conn_q + 1'b1;
      if (drop && drop_q != '1)      drop_q <= drop_q + 1'b1;
    end
  end

  assign node_cnt = node_q;
  assign conn_cnt = conn_q;
  assign drop_cnt = drop_q;
`else
  assign node_cnt = '0;
  assign conn_cnt = '0;
  assign drop_cnt = '0;
`endif

endmodule
